// File: rtl/frame_buf_manager.sv
// N-way frame-buffer rotation between a camera writer and a display reader.
// Hands the writer a free DDR base and the reader the newest completed frame.
module frame_buf_manager #(
  parameter int          NUM_BUF    = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0010_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_100Mhz,
  input  logic             sys_rst_n,
  input  logic             wr_frame_done,
  input  logic             rd_vsync_pulse,
  input  logic             freeze,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic [2:0]       wr_idx,
  output logic [2:0]       rd_idx,
  output logic             ready_valid,
  output logic [CNT_W-1:0] frames_written,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated
);

  localparam logic [2:0]       LAST_IDX = 3'(NUM_BUF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [31:0] addr_of(input logic [2:0] i);
    return BASE_ADDR + {29'd0, i} * BUF_STRIDE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != CNT_MAX)) ? c + CNT_ONE : c;
  endfunction

  // Frame-done crosses from the pixel clock: two sync flops plus one for edge detect.
  logic sync1_reg, sync2_reg, sync3_reg;
  logic done_pulse;
  assign done_pulse = sync2_reg & ~sync3_reg;

  logic [2:0]       wr_idx_reg, rd_idx_reg, ready_idx_reg;
  logic             ready_valid_reg;
  logic [31:0]      wr_base_reg, rd_base_reg;
  logic [CNT_W-1:0] written_reg, dropped_reg, repeated_reg;

  logic       consume;
  logic [2:0] rd_next, wr_step, wr_next, ready_idx_next;
  logic       ready_valid_next;
  logic       dropped_inc, repeated_inc;

  // Reader decides first on pre-edge state; the writer then avoids whatever the reader will hold.
  always_comb begin
    consume          = rd_vsync_pulse & ~freeze & ready_valid_reg;
    rd_next          = consume ? ready_idx_reg : rd_idx_reg;
    wr_step          = next_idx(wr_idx_reg);
    wr_next          = wr_idx_reg;
    ready_idx_next   = ready_idx_reg;
    ready_valid_next = ready_valid_reg & ~consume;
    if (done_pulse) begin
      wr_next          = (wr_step == rd_next) ? next_idx(wr_step) : wr_step;
      ready_idx_next   = wr_idx_reg;
      ready_valid_next = 1'b1;
    end
    dropped_inc  = done_pulse & ready_valid_reg & ~consume;
    repeated_inc = rd_vsync_pulse & ~consume;
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!sys_rst_n) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      sync3_reg       <= 1'b0;
      wr_idx_reg      <= 3'd0;
      rd_idx_reg      <= LAST_IDX;
      ready_idx_reg   <= LAST_IDX;
      ready_valid_reg <= 1'b0;
      wr_base_reg     <= addr_of(3'd0);
      rd_base_reg     <= addr_of(LAST_IDX);
      written_reg     <= '0;
      dropped_reg     <= '0;
      repeated_reg    <= '0;
    end else begin
      sync1_reg       <= wr_frame_done;
      sync2_reg       <= sync1_reg;
      sync3_reg       <= sync2_reg;
      wr_idx_reg      <= wr_next;
      rd_idx_reg      <= rd_next;
      ready_idx_reg   <= ready_idx_next;
      ready_valid_reg <= ready_valid_next;
      // Addresses derive from the next index so they land on the same edge as the index.
      wr_base_reg     <= addr_of(wr_next);
      rd_base_reg     <= addr_of(rd_next);
      written_reg     <= sat_inc(written_reg, done_pulse);
      dropped_reg     <= sat_inc(dropped_reg, dropped_inc);
      repeated_reg    <= sat_inc(repeated_reg, repeated_inc);
    end
  end

  assign wr_idx          = wr_idx_reg;
  assign rd_idx          = rd_idx_reg;
  assign ready_valid     = ready_valid_reg;
  assign wr_base_addr    = wr_base_reg;
  assign rd_base_addr    = rd_base_reg;
  assign frames_written  = written_reg;
  assign frames_dropped  = dropped_reg;
  assign frames_repeated = repeated_reg;

endmodule

// File: tb/tb_frame_buf_manager.sv
// Scoreboard bench for frame_buf_manager (3 buffers, 4-bit counters so saturation is reachable).
// Stimulus pushes hand-computed expected states; a negedge monitor pops and compares them.
module tb_frame_buf_manager;

  localparam int NB = 3;
  localparam int CW = 4;

  logic          clk_100Mhz = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          rd_vsync_pulse = 1'b0;
  logic          freeze = 1'b0;
  logic [31:0]   wr_base_addr, rd_base_addr;
  logic [2:0]    wr_idx, rd_idx;
  logic          ready_valid;
  logic [CW-1:0] frames_written, frames_dropped, frames_repeated;

  always #5 clk_100Mhz = ~clk_100Mhz;

  frame_buf_manager #(.NUM_BUF(NB), .CNT_W(CW)) dut (
    .clk_100Mhz     (clk_100Mhz),
    .sys_rst_n      (sys_rst_n),
    .wr_frame_done  (wr_frame_done),
    .rd_vsync_pulse (rd_vsync_pulse),
    .freeze         (freeze),
    .wr_base_addr   (wr_base_addr),
    .rd_base_addr   (rd_base_addr),
    .wr_idx         (wr_idx),
    .rd_idx         (rd_idx),
    .ready_valid    (ready_valid),
    .frames_written (frames_written),
    .frames_dropped (frames_dropped),
    .frames_repeated(frames_repeated)
  );

  typedef struct {
    int    cyc;
    string name;
    int    wi, ri, rv, fw, fd, fr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  function automatic logic [31:0] base_of(input int idx);
    return 32'h0100_0000 + 32'(idx) * 32'h0010_0000;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: invariants every cycle, scoreboard entries on the cycle they target.
  always @(negedge clk_100Mhz) begin
    exp_t e;
    chk("inv_wr_ne_rd", 32'(wr_idx != rd_idx), 32'd1);
    chk("inv_idx_range", 32'((wr_idx < 3'(NB)) && (rd_idx < 3'(NB))), 32'd1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk({e.name, ".late"}, 32'(cyc), 32'(e.cyc));
      end else begin
        chk({e.name, ".wr_idx"},   32'(wr_idx),          32'(e.wi));
        chk({e.name, ".rd_idx"},   32'(rd_idx),          32'(e.ri));
        chk({e.name, ".ready"},    32'(ready_valid),     32'(e.rv));
        chk({e.name, ".written"},  32'(frames_written),  32'(e.fw));
        chk({e.name, ".dropped"},  32'(frames_dropped),  32'(e.fd));
        chk({e.name, ".repeated"}, 32'(frames_repeated), 32'(e.fr));
        chk({e.name, ".wr_base"},  wr_base_addr,         base_of(e.wi));
        chk({e.name, ".rd_base"},  rd_base_addr,         base_of(e.ri));
        $display("txn %s cyc=%0d wr=%0d rd=%0d rv=%0d w/d/r=%0d/%0d/%0d",
                 e.name, cyc, wr_idx, rd_idx, ready_valid,
                 frames_written, frames_dropped, frames_repeated);
      end
    end
  end

  task automatic tick();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic expect_state(input string nm, input int wi, input int ri, input int rv,
                              input int fw, input int fd, input int fr);
    exp_t e;
    e.cyc = cyc; e.name = nm;
    e.wi = wi; e.ri = ri; e.rv = rv; e.fw = fw; e.fd = fd; e.fr = fr;
    sb.push_back(e);
  endtask

  // Quiet gap lets the sync chain settle low, then the level rises; update lands on the 3rd edge.
  task automatic do_done();
    repeat (3) tick();
    wr_frame_done = 1'b1;
    repeat (3) tick();
    wr_frame_done = 1'b0;
  endtask

  task automatic do_vsync();
    rd_vsync_pulse = 1'b1;
    tick();
    rd_vsync_pulse = 1'b0;
  endtask

  task automatic do_both();
    repeat (3) tick();
    wr_frame_done = 1'b1;
    repeat (2) tick();
    rd_vsync_pulse = 1'b1;
    tick();
    rd_vsync_pulse = 1'b0;
    wr_frame_done  = 1'b0;
  endtask

  // Freeze phase: 1 = vsync, 0 = done; expected wr_idx / written / dropped / repeated after each.
  int fz_vs [14] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  int fz_wi [14] = '{1, 1, 2, 1, 1, 2, 1, 1, 2, 1, 1, 2, 1, 2};
  int fz_fw [14] = '{6, 6, 7, 8, 8, 9, 10, 10, 11, 12, 12, 13, 14, 15};
  int fz_fd [14] = '{1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 7, 8, 9, 10};
  int fz_fr [14] = '{1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 5};

  initial begin
    tick(); tick();
    expect_state("rst_hold", 0, 2, 0, 0, 0, 0);
    sys_rst_n = 1'b1;
    tick();
    expect_state("rst_release", 0, 2, 0, 0, 0, 0);

    // First frame: nothing moves on the 2nd edge, everything on the 3rd.
    repeat (3) tick();
    wr_frame_done = 1'b1;
    repeat (2) tick();
    expect_state("t2_latency", 0, 2, 0, 0, 0, 0);
    tick();
    expect_state("t2_done", 1, 2, 1, 1, 0, 0);
    wr_frame_done = 1'b0;
    do_vsync();
    expect_state("t2_vsync", 1, 0, 0, 1, 0, 0);

    do_done();  expect_state("t3_done1", 2, 0, 1, 2, 0, 0);
    do_done();  expect_state("t3_done2_skip", 1, 0, 1, 3, 1, 0);
    do_vsync(); expect_state("t3_vsync", 1, 2, 0, 3, 1, 0);

    do_done();  expect_state("t4_setup", 0, 2, 1, 4, 1, 0);
    do_both();  expect_state("t4_both", 2, 1, 1, 5, 1, 0);
    do_vsync(); expect_state("t4_take", 2, 0, 0, 5, 1, 0);
    do_vsync(); expect_state("t4_repeat", 2, 0, 0, 5, 1, 1);

    freeze = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (fz_vs[i] != 0) do_vsync();
      else do_done();
      expect_state($sformatf("t5_frz%0d", i), fz_wi[i], 0, 1, fz_fw[i], fz_fd[i], fz_fr[i]);
    end
    for (int k = 11; k <= 16; k++) begin
      do_done();
      expect_state($sformatf("sat_done%0d", k), (k % 2 == 1) ? 1 : 2, 0, 1, 15,
                   (k > 15) ? 15 : k, 5);
    end
    for (int k = 1; k <= 12; k++) begin
      do_vsync();
      expect_state($sformatf("sat_vs%0d", k), 2, 0, 1, 15, 15, (5 + k > 15) ? 15 : 5 + k);
    end
    freeze = 1'b0;
    do_vsync(); expect_state("unfreeze", 2, 1, 0, 15, 15, 15);

    // Reset while a done edge is in the synchroniser: it must not survive.
    repeat (3) tick();
    wr_frame_done = 1'b1;
    repeat (2) tick();
    sys_rst_n = 1'b0;
    tick();
    expect_state("mid_rst", 0, 2, 0, 0, 0, 0);
    wr_frame_done = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    repeat (4) tick();
    expect_state("post_rst_idle", 0, 2, 0, 0, 0, 0);
    do_done();  expect_state("post_rst_done", 1, 2, 1, 1, 0, 0);

    repeat (3) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, expected at cycle %0d, now %0d", e.name, e.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
